// File: rtl/gap_mem_pkg.sv
// Shared defaults and helpers for the GAP row-wide frame memory.
package gap_mem_pkg;

  localparam int LANES_DEF  = 32;
  localparam int DATA_W_DEF = 16;
  localparam int ROW_AW_DEF = 8;

  typedef logic [LANES_DEF*DATA_W_DEF-1:0] row_t;

  // Bit offset of a lane inside a packed row.
  function automatic int lane_idx(input int lane, input int dataW);
    return lane * dataW;
  endfunction

  // Extracts a width-bit field starting at lsb from a flat host address.
  function automatic int addr_field(input logic [63:0] addr, input int lsb, input int width);
    logic [63:0] shifted;
    shifted = addr >> lsb;
    return int'(shifted & ((64'd1 << width) - 64'd1));
  endfunction

endpackage

// File: rtl/gap_mem_bank.sv
// One frame bank: 2**ROW_AW rows of LANES words, per-lane masked write, registered read-first port.
module gap_mem_bank #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int ROW_AW = 8
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [ROW_AW-1:0]         waddr_i,
  input  logic [LANES-1:0]          wmask_i,
  input  logic [LANES*DATA_W-1:0]   wdata_i,
  input  logic                      re_i,
  input  logic [ROW_AW-1:0]         raddr_i,
  output logic [LANES*DATA_W-1:0]   rdata_o
);

  logic [LANES*DATA_W-1:0] mem_q [2**ROW_AW];
  logic [LANES*DATA_W-1:0] rdata_q;

  // Read returns the row as it was before any write on the same edge.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    for (int i = 0; i < LANES; i++) begin
      if (we_i && wmask_i[i]) begin
        mem_q[waddr_i][i*DATA_W +: DATA_W] <= wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gap_row_mem.sv
// Row-wide multi-bank frame memory for the GAP engine with a stall-aware single-word host port.
module gap_row_mem
  import gap_mem_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROW_AW     = ROW_AW_DEF,
  parameter int NUM_FRAMES = 4,
  parameter int RD_LAT     = 1,
  parameter int FWD        = 1,
  localparam int FW  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int RW  = LANES * DATA_W,
  localparam int HAW = FW + ROW_AW + LW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic [FW-1:0]     rframe,
  input  logic [ROW_AW-1:0] raddr,
  output logic [RW-1:0]     rdata,
  output logic              rvalid,
  input  logic              wen,
  input  logic [FW-1:0]     wframe,
  input  logic [ROW_AW-1:0] waddr,
  input  logic [LANES-1:0]  wmask,
  input  logic [RW-1:0]     wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [HAW-1:0]    host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid
);

  logic [63:0]       hostAddrExt;
  logic [LW-1:0]     hostLane;
  logic [ROW_AW-1:0] hostRow;
  logic [FW-1:0]     hostFrame;
  logic              hostWr;
  logic              hostRd;

  logic              bankWen;
  logic [FW-1:0]     bankWframe;
  logic [ROW_AW-1:0] bankWaddr;
  logic [LANES-1:0]  bankWmask;
  logic [RW-1:0]     bankWdata;
  logic              bankRen;
  logic [FW-1:0]     bankRframe;
  logic [ROW_AW-1:0] bankRaddr;
  logic [RW-1:0]     bankRdata [NUM_FRAMES];

  logic              rdValid_q;
  logic [FW-1:0]     rdFrame_q;
  logic              fwdHit_d;
  logic              fwdHit_q;
  logic [LANES-1:0]  fwdMask_q;
  logic [RW-1:0]     fwdData_q;
  logic              hostRvalid_q;
  logic [FW-1:0]     hostFrame_q;
  logic [LW-1:0]     hostLane_q;

  logic [FW-1:0]     selFrame;
  logic [RW-1:0]     selRow;
  logic [RW-1:0]     mergedRow;
  logic [DATA_W-1:0] hostWord;

  assign hostAddrExt = 64'(host_addr);
  assign hostLane    = LW'(addr_field(hostAddrExt, 0, LW));
  assign hostRow     = ROW_AW'(addr_field(hostAddrExt, LW, ROW_AW));
  assign hostFrame   = FW'(addr_field(hostAddrExt, LW + ROW_AW, FW));

  // The engine owns the array whenever it is active; the host only gets idle cycles.
  assign host_ack = host_req & ~ren & ~wen;
  assign hostWr   = host_ack & host_we;
  assign hostRd   = host_ack & ~host_we;

  assign bankWen    = wen | hostWr;
  assign bankWframe = wen ? wframe : hostFrame;
  assign bankWaddr  = wen ? waddr  : hostRow;
  assign bankWmask  = wen ? wmask  : (LANES'(1) << hostLane);
  assign bankWdata  = wen ? wdata  : {LANES{host_wdata}};
  assign bankRen    = ren | hostRd;
  assign bankRframe = ren ? rframe : hostFrame;
  assign bankRaddr  = ren ? raddr  : hostRow;

  for (genvar g = 0; g < NUM_FRAMES; g++) begin : g_bank
    gap_mem_bank #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .ROW_AW (ROW_AW)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (bankWen && (bankWframe == FW'(g))),
      .waddr_i (bankWaddr),
      .wmask_i (bankWmask),
      .wdata_i (bankWdata),
      .re_i    (bankRen && (bankRframe == FW'(g))),
      .raddr_i (bankRaddr),
      .rdata_o (bankRdata[g])
    );
  end

  // Banks are read-first, so a same-row write is patched in afterwards from captured wdata.
  assign fwdHit_d = (FWD != 0) && ren && wen && (rframe == wframe) && (raddr == waddr)
                    && (int'(wframe) < NUM_FRAMES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdValid_q    <= 1'b0;
      hostRvalid_q <= 1'b0;
      fwdHit_q     <= 1'b0;
    end else begin
      rdValid_q    <= ren;
      hostRvalid_q <= hostRd;
      fwdHit_q     <= fwdHit_d;
    end
    if (ren) begin
      rdFrame_q <= rframe;
      fwdMask_q <= wmask;
      fwdData_q <= wdata;
    end
    if (hostRd) begin
      hostFrame_q <= hostFrame;
      hostLane_q  <= hostLane;
    end
  end

  // A bank index with no bank behind it matches nothing and reads as zero.
  assign selFrame = rdValid_q ? rdFrame_q : hostFrame_q;

  always_comb begin
    selRow = '0;
    for (int f = 0; f < NUM_FRAMES; f++) begin
      if (selFrame == FW'(f)) begin
        selRow = bankRdata[f];
      end
    end
  end

  always_comb begin
    mergedRow = '0;
    if (rdValid_q) begin
      for (int i = 0; i < LANES; i++) begin
        mergedRow[lane_idx(i, DATA_W) +: DATA_W] = (fwdHit_q && fwdMask_q[i])
          ? fwdData_q[lane_idx(i, DATA_W) +: DATA_W]
          : selRow[lane_idx(i, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    hostWord = '0;
    if (hostRvalid_q) begin
      hostWord = selRow[lane_idx(int'(hostLane_q), DATA_W) +: DATA_W];
    end
  end

  assign host_rdata  = hostWord;
  assign host_rvalid = hostRvalid_q;

  if (RD_LAT == 2) begin : g_lat2
    logic [RW-1:0] rdata_q;
    logic          rvalid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= mergedRow;
        rvalid_q <= rdValid_q;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_lat1
    assign rdata  = mergedRow;
    assign rvalid = rdValid_q;
  end

endmodule

// File: tb/tb_gap_row_mem.sv
// Directed self-checking bench for gap_row_mem with default parameters (RD_LAT=1, FWD=1).
module tb_gap_row_mem;
  import gap_mem_pkg::*;

  localparam int LANES  = 32;
  localparam int DATA_W = 16;
  localparam int ROW_AW = 8;
  localparam int FW     = 2;
  localparam int LW     = 5;
  localparam int RW     = LANES * DATA_W;
  localparam int HAW    = FW + ROW_AW + LW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ren;
  logic [FW-1:0]     rframe;
  logic [ROW_AW-1:0] raddr;
  logic [RW-1:0]     rdata;
  logic              rvalid;
  logic              wen;
  logic [FW-1:0]     wframe;
  logic [ROW_AW-1:0] waddr;
  logic [LANES-1:0]  wmask;
  logic [RW-1:0]     wdata;
  logic              host_req;
  logic              host_we;
  logic [HAW-1:0]    host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  int compared   = 0;
  int mismatched = 0;
  logic [RW-1:0] expRow3;

  gap_row_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ren         (ren),
    .rframe      (rframe),
    .raddr       (raddr),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .wen         (wen),
    .wframe      (wframe),
    .waddr       (waddr),
    .wmask       (wmask),
    .wdata       (wdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [RW-1:0] observed, input logic [RW-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [RW-1:0] fillRow(input logic [DATA_W-1:0] w);
    logic [RW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = w;
    return r;
  endfunction

  function automatic logic [RW-1:0] patRow(input int f, input int row);
    logic [RW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = 16'((f << 13) | (row << 5) | i);
    return r;
  endfunction

  task automatic readRow(input string tag, input int f, input int row, input logic [RW-1:0] expected);
    ren = 1'b1; rframe = FW'(f); raddr = ROW_AW'(row);
    applyStimulus();
    ren = 1'b0;
    checkOutput({tag, "_rvalid"}, RW'(rvalid), RW'(1));
    checkOutput({tag, "_rdata"}, rdata, expected);
  endtask

  initial begin
    rst_n = 1'b0; ren = 1'b0; rframe = '0; raddr = '0;
    wen = 1'b0; wframe = '0; waddr = '0; wmask = '0; wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    expRow3 = '0;
    applyStimulus();
    applyStimulus();
    $display("[TB] reset state");
    checkOutput("rst_rvalid", RW'(rvalid), RW'(0));
    checkOutput("rst_rdata", rdata, '0);
    checkOutput("rst_host_rvalid", RW'(host_rvalid), RW'(0));
    checkOutput("rst_host_rdata", RW'(host_rdata), RW'(0));
    rst_n = 1'b1;
    applyStimulus();

    $display("[TB] host word load of frame 0 row 3");
    host_req = 1'b1; host_we = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      host_addr  = {2'(0), 8'(3), 5'(i)};
      host_wdata = 16'(16'h0101 + i);
      expRow3[i*DATA_W +: DATA_W] = 16'(16'h0101 + i);
      #1;
      checkOutput($sformatf("host_ack_wr%0d", i), RW'(host_ack), RW'(1));
      applyStimulus();
    end
    host_req = 1'b0; host_we = 1'b0;
    readRow("t1_read", 0, 3, expRow3);
    applyStimulus();
    checkOutput("t1_idle_rvalid", RW'(rvalid), RW'(0));
    checkOutput("t1_idle_rdata", rdata, '0);

    $display("[TB] masked engine write");
    wen = 1'b1; wframe = 2'd0; waddr = 8'd3; wmask = 32'h0000_00FF; wdata = fillRow(16'hBEEF);
    for (int i = 0; i < 8; i++) expRow3[i*DATA_W +: DATA_W] = 16'hBEEF;
    applyStimulus();
    wen = 1'b0;
    readRow("t2_masked", 0, 3, expRow3);
    wen = 1'b1; wmask = '0; wdata = fillRow(16'h1234);
    applyStimulus();
    wen = 1'b0;
    readRow("t2_zero_mask", 0, 3, expRow3);

    $display("[TB] read/write collision forwarding");
    ren = 1'b1; rframe = 2'd0; raddr = 8'd3;
    wen = 1'b1; wframe = 2'd0; waddr = 8'd3; wmask = '1; wdata = fillRow(16'hAAAA);
    applyStimulus();
    ren = 1'b0; wen = 1'b0;
    checkOutput("t3_full_rvalid", RW'(rvalid), RW'(1));
    checkOutput("t3_full_rdata", rdata, fillRow(16'hAAAA));
    expRow3 = fillRow(16'hAAAA);
    ren = 1'b1; wen = 1'b1; wmask = 32'h0000_FFFF; wdata = fillRow(16'h5555);
    applyStimulus();
    ren = 1'b0; wen = 1'b0;
    for (int i = 0; i < 16; i++) expRow3[i*DATA_W +: DATA_W] = 16'h5555;
    checkOutput("t3_part_rdata", rdata, expRow3);
    readRow("t3_reread", 0, 3, expRow3);

    $display("[TB] host stall behind engine reads");
    host_req = 1'b1; host_we = 1'b1; host_addr = {2'(0), 8'(3), 5'(5)}; host_wdata = 16'h5A5A;
    applyStimulus();
    expRow3[5*DATA_W +: DATA_W] = 16'h5A5A;
    host_we = 1'b0;
    ren = 1'b1; rframe = 2'd0; raddr = 8'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("t4_stall_ack%0d", k), RW'(host_ack), RW'(0));
      applyStimulus();
      checkOutput($sformatf("t4_stall_rdata%0d", k), rdata, expRow3);
    end
    ren = 1'b0;
    #1;
    checkOutput("t4_ack", RW'(host_ack), RW'(1));
    applyStimulus();
    host_req = 1'b0;
    checkOutput("t4_host_rvalid", RW'(host_rvalid), RW'(1));
    checkOutput("t4_host_rdata", RW'(host_rdata), RW'(16'h5A5A));
    applyStimulus();
    checkOutput("t4_host_rvalid_drop", RW'(host_rvalid), RW'(0));

    $display("[TB] back-to-back sweep of frame 2");
    wen = 1'b1; wmask = '1;
    for (int f = 1; f <= 2; f++) begin
      for (int r = 0; r < 256; r++) begin
        wframe = FW'(f); waddr = ROW_AW'(r); wdata = patRow(f, r);
        applyStimulus();
      end
    end
    wen = 1'b0;
    ren = 1'b1; rframe = 2'd2;
    for (int r = 0; r <= 256; r++) begin
      raddr = ROW_AW'(r);
      applyStimulus();
      checkOutput($sformatf("t5_rvalid%0d", r), RW'(rvalid), RW'(1));
      checkOutput($sformatf("t5_rdata%0d", r), rdata, patRow(2, r % 256));
    end
    ren = 1'b0;
    readRow("t5_frame1", 1, 7, patRow(1, 7));

    $display("[TB] reset with read in flight");
    ren = 1'b1; rframe = 2'd2; raddr = 8'd9;
    rst_n = 1'b0;
    applyStimulus();
    ren = 1'b0;
    checkOutput("t6_rvalid", RW'(rvalid), RW'(0));
    checkOutput("t6_rdata", rdata, '0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("t6_rvalid_after", RW'(rvalid), RW'(0));
    readRow("t6_keep_f2", 2, 9, patRow(2, 9));
    readRow("t6_keep_f0", 0, 3, expRow3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
